// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spart_pkg
// Description : Shared definitions for the SPART bus driver: register
//               addresses, baud divisor constants, FSM state encoding and
//               the baud-select to divisor lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

    // SPART register select values
    localparam logic [1:0] c_addr_buf    = 2'b00;  // TX/RX buffer
    localparam logic [1:0] c_addr_status = 2'b01;  // status (never accessed)
    localparam logic [1:0] c_addr_dbl    = 2'b10;  // divisor low byte
    localparam logic [1:0] c_addr_dbh    = 2'b11;  // divisor high byte

    // round(50e6 / (16 * baud)) - 1
    localparam logic [15:0] c_div_4800  = 16'h028A;
    localparam logic [15:0] c_div_9600  = 16'h0145;
    localparam logic [15:0] c_div_19200 = 16'h00A2;
    localparam logic [15:0] c_div_38400 = 16'h0050;

    typedef enum logic [2:0] {
        WR_DBL   = 3'd0,
        WR_DBH   = 3'd1,
        WAIT_RDA = 3'd2,
        RD_RX    = 3'd3,
        WAIT_TBR = 3'd4,
        WR_TX    = 3'd5
    } state_t;

    function automatic logic [15:0] divisor_for(input logic [1:0] sel);
        logic [15:0] div;
        case (sel)
            2'b00:   div = c_div_4800;
            2'b01:   div = c_div_9600;
            2'b10:   div = c_div_19200;
            default: div = c_div_38400;
        endcase
        return div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spart_driver.sv
`default_nettype none
// ============================================================================
// Module      : spart_driver
// Description : Bus initiator for a SPART. Programs the baud divisor from
//               br_cfg, then echoes every received byte back through the
//               transmitter. Every bus access is a single-cycle strobe.
// Ports       : clk      - system clock (50 MHz), rising edge
//               rst      - synchronous active-high reset
//               br_cfg   - baud select 00=4800 01=9600 10=19200 11=38400
//               rda      - receive data available
//               tbr      - transmit buffer ready
//               iocs     - chip select, high for exactly one cycle per access
//               iorw     - 1 = read from SPART, 0 = write to SPART
//               ioaddr   - register select
//               databus  - shared bidirectional data bus
//               last_rx  - last byte read from the RX buffer
// Revision    : 1.0 - initial release
// ============================================================================
module spart_driver
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [7:0] last_rx
);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_br_cfg;
    logic [7:0]  r_last_rx;
    logic [7:0]  r_echo;

    logic        w_cs;
    logic        w_rw;
    logic [1:0]  w_addr;
    logic [7:0]  w_dout;
    logic        w_cfg_change;
    logic [15:0] w_divisor;

    assign w_divisor    = divisor_for(r_br_cfg);
    assign w_cfg_change = (r_state == WAIT_RDA) && (br_cfg != r_br_cfg);

    // ------------------------------------------------------------------
    // State register and data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= WR_DBL;
            r_br_cfg  <= br_cfg;
            r_last_rx <= 8'h00;
            r_echo    <= 8'h00;
        end else begin
            r_state <= w_next_state;
            if (w_cfg_change) begin
                r_br_cfg <= br_cfg;
            end
            // The SPART drives the bus for the whole read cycle; capture it
            // at the closing edge.
            if (r_state == RD_RX) begin
                r_last_rx <= databus;
                r_echo    <= databus;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and raw access decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_cs         = 1'b0;
        w_rw         = 1'b1;
        w_addr       = c_addr_buf;
        w_dout       = 8'h00;
        case (r_state)
            WR_DBL: begin
                w_cs         = 1'b1;
                w_rw         = 1'b0;
                w_addr       = c_addr_dbl;
                w_dout       = w_divisor[7:0];
                w_next_state = WR_DBH;
            end
            WR_DBH: begin
                w_cs         = 1'b1;
                w_rw         = 1'b0;
                w_addr       = c_addr_dbh;
                w_dout       = w_divisor[15:8];
                w_next_state = WAIT_RDA;
            end
            WAIT_RDA: begin
                // A baud change wins over pending receive data so the
                // divisor is always current before the next transfer.
                if (w_cfg_change) begin
                    w_next_state = WR_DBL;
                end else if (rda) begin
                    w_next_state = RD_RX;
                end
            end
            RD_RX: begin
                w_cs         = 1'b1;
                w_rw         = 1'b1;
                w_addr       = c_addr_buf;
                w_next_state = WAIT_TBR;
            end
            WAIT_TBR: begin
                if (tbr) begin
                    w_next_state = WR_TX;
                end
            end
            WR_TX: begin
                w_cs         = 1'b1;
                w_rw         = 1'b0;
                w_addr       = c_addr_buf;
                w_dout       = r_echo;
                w_next_state = WAIT_RDA;
            end
            default: begin
                w_next_state = WR_DBL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus outputs. Reset masks the strobe so an access in flight when rst
    // rises is abandoned in that same cycle.
    // ------------------------------------------------------------------
    assign iocs    = w_cs & ~rst;
    assign iorw    = iocs ? w_rw : 1'b1;
    assign ioaddr  = iocs ? w_addr : c_addr_buf;
    assign databus = (iocs && !iorw) ? w_dout : 8'hzz;
    assign last_rx = r_last_rx;

endmodule
`default_nettype wire

// File: tb/tb_spart_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_spart_driver
// Description : Directed self-checking bench for spart_driver. A weak
//               pull-up on the data bus makes an undriven bus read as 0xFF.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_driver;

    logic       clk;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] last_rx;

    logic [7:0] r_tb_rx;      // byte the modelled SPART returns on reads
    int         n_checks;
    int         n_fail;
    logic       r_prev_cs;
    logic [1:0] r_prev_addr;

    spart_driver u_dut (
        .clk     (clk),
        .rst     (rst),
        .br_cfg  (br_cfg),
        .rda     (rda),
        .tbr     (tbr),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .last_rx (last_rx)
    );

    // Modelled SPART drives the RX byte during read strobes
    assign databus = (iocs && iorw) ? r_tb_rx : 8'hzz;

    for (genvar i = 0; i < 8; i++) begin : g_pullup
        pullup pu (databus[i]);
    end

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus invariants checked on every sampled cycle
    task automatic invariants();
        if (!iocs) begin
            chk("idle_iorw", {15'd0, iorw}, 16'd1);
            chk("idle_ioaddr", {14'd0, ioaddr}, 16'd0);
            chk("idle_bus_z", {8'd0, databus}, 16'h00FF);
        end else if (iorw) begin
            chk("read_bus_not_driven", {8'd0, databus}, {8'd0, r_tb_rx});
        end
        if (r_prev_cs && iocs) begin
            chk("back_to_back_cs", {12'd0, r_prev_addr, ioaddr}, {12'd0, 2'b10, 2'b11});
        end
        r_prev_cs   = iocs;
        r_prev_addr = ioaddr;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        invariants();
    endtask

    task automatic expect_write(input string tag, input logic [1:0] addr, input logic [7:0] data);
        chk({tag, "_cs"}, {15'd0, iocs}, 16'd1);
        chk({tag, "_rw"}, {15'd0, iorw}, 16'd0);
        chk({tag, "_addr"}, {14'd0, ioaddr}, {14'd0, addr});
        chk({tag, "_data"}, {8'd0, databus}, {8'd0, data});
    endtask

    task automatic expect_read(input string tag);
        chk({tag, "_cs"}, {15'd0, iocs}, 16'd1);
        chk({tag, "_rw"}, {15'd0, iorw}, 16'd1);
        chk({tag, "_addr"}, {14'd0, ioaddr}, 16'd0);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_cs"}, {15'd0, iocs}, 16'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        r_prev_cs   = 1'b0;
        r_prev_addr = 2'b00;
        rst         = 1'b1;
        br_cfg      = 2'b01;
        rda         = 1'b0;
        tbr         = 1'b0;
        r_tb_rx     = 8'h00;

        // ---- Reset with 9600 baud, then divisor programming ----
        tick();
        expect_idle("rst_cycle");
        tick();
        expect_idle("rst_cycle2");
        chk("rst_last_rx", {8'd0, last_rx}, 16'h0000);
        rst = 1'b0;
        #1;
        expect_write("dbl_9600", 2'b10, 8'h45);
        tick();
        expect_write("dbh_9600", 2'b11, 8'h01);
        tick();
        expect_idle("after_prog");
        tick();
        expect_idle("idle_wait");

        // ---- Echo with tbr already high ----
        rda = 1'b1; tbr = 1'b1; r_tb_rx = 8'h5A;
        tick();
        expect_read("rx1");
        rda = 1'b0;
        tick();
        expect_idle("rx1_wait_tbr");
        chk("rx1_last_rx", {8'd0, last_rx}, 16'h005A);
        tick();
        expect_write("tx1", 2'b00, 8'h5A);
        tick();
        expect_idle("tx1_done");

        // ---- tbr held low for 20 cycles ----
        tbr = 1'b0; rda = 1'b1; r_tb_rx = 8'hC3;
        tick();
        expect_read("rx2");
        rda = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_idle("rx2_hold");
        end
        chk("rx2_last_rx", {8'd0, last_rx}, 16'h00C3);
        tbr = 1'b1;
        tick();
        expect_write("tx2", 2'b00, 8'hC3);
        tick();
        expect_idle("tx2_single_a");
        tick();
        expect_idle("tx2_single_b");

        // ---- Baud change 01->11 coinciding with rda ----
        br_cfg = 2'b11; rda = 1'b1; r_tb_rx = 8'h96;
        tick();
        expect_write("dbl_38400", 2'b10, 8'h50);
        tick();
        expect_write("dbh_38400", 2'b11, 8'h00);
        tick();
        expect_idle("cfg_wait");
        tick();
        expect_read("rx3");
        rda = 1'b0;
        tick();
        expect_idle("rx3_wait_tbr");
        chk("rx3_last_rx", {8'd0, last_rx}, 16'h0096);
        tick();
        expect_write("tx3", 2'b00, 8'h96);
        tick();
        expect_idle("tx3_done");

        // ---- Baud change to 19200 ----
        br_cfg = 2'b10;
        tick();
        expect_write("dbl_19200", 2'b10, 8'hA2);
        tick();
        expect_write("dbh_19200", 2'b11, 8'h00);
        tick();
        expect_idle("cfg2_wait");

        // ---- Reset during WAIT_TBR; br_cfg change there is ignored ----
        tbr = 1'b0; rda = 1'b1; r_tb_rx = 8'h77;
        tick();
        expect_read("rx4");
        rda = 1'b0;
        tick();
        chk("rx4_last_rx", {8'd0, last_rx}, 16'h0077);
        br_cfg = 2'b00;
        tick();
        expect_idle("wait_tbr_cfg_ignored");
        tbr = 1'b1; rst = 1'b1;
        #1;
        expect_idle("rst_mid_wait_tbr");
        tick();
        expect_idle("rst_cycle3");
        chk("rst3_last_rx", {8'd0, last_rx}, 16'h0000);
        rst = 1'b0;
        #1;
        expect_write("dbl_4800", 2'b10, 8'h8A);
        tick();
        expect_write("dbh_4800", 2'b11, 8'h02);
        tick();
        expect_idle("no_tx_after_rst_a");
        tick();
        expect_idle("no_tx_after_rst_b");

        // ---- Reset in the middle of a TX write abandons it ----
        rda = 1'b1; r_tb_rx = 8'h3C;
        tick();
        expect_read("rx5");
        rda = 1'b0;
        tick();
        tick();
        expect_write("tx5", 2'b00, 8'h3C);
        rst = 1'b1;
        #1;
        expect_idle("rst_mid_tx");
        tick();
        rst = 1'b0;
        #1;
        expect_write("dbl_after_tx_rst", 2'b10, 8'h8A);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
